uart_tx_out: RTL and testbench
==============================

// Module: uart_tx_out
// PURPOSE
// - Output-side UART transmitter; the serial path leaving the FPGA, paired with the synchronized RX path.
// - Accepts bytes over an AXI-Stream-style valid/ready handshake and serializes them 8N1 (optional parity), LSB first.
// - Sits in the 100 MHz system domain. The txd register feeds the top-level OBUF directly, with no logic in between.
// PARAMETERS
// - DATA_WIDTH    8    payload bits per frame (5..9)
// - CLKS_PER_BIT  868  clk cycles per bit (100 MHz / 115200); elaboration error if < 2
// PORTS
// - clk            in   1           system clock (100 MHz)
// - rst            in   1           synchronous reset, active-high
// - s_axis_tdata   in   DATA_WIDTH  byte to send
// - s_axis_tvalid  in   1           tdata valid
// - s_axis_tready  out  1           block can accept a byte
// - txd            out  1           serial line, idle high, registered
// - busy           out  1           frame in progress
// BEHAVIOUR
// - Single clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
// - Reset values: txd=1, s_axis_tready=0, busy=0, state=IDLE, bit counter=0, prescale counter=0.
// - First cycle after reset is released: s_axis_tready=1.
// - All outputs are registered; no combinational path from input to output.
// - States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
// - IDLE:
//   - s_axis_tready=1, txd=1, busy=0.
//   - On tvalid&&tready: latch tdata into a shift register and go to START.
//   - Next cycle: tready=0, busy=1, txd=0 (1-cycle latency from accept to the start edge).
// - Bit timing: each state holds txd for exactly CLKS_PER_BIT cycles, using a prescale counter 0..CLKS_PER_BIT-1.
//   - The counter is $clog2(CLKS_PER_BIT) bits wide and reloads to 0 on every bit boundary.
// - START: txd=0.
// - DATA: txd=shreg[0], then shift right at each bit boundary. The bit counter counts 0..DATA_WIDTH-1.
// - STOP: txd=1 for one bit time.
//   - After its last cycle, go to IDLE; tready=1 and busy=0 in that same next cycle.
// - Frame length: (2+DATA_WIDTH[+1])*CLKS_PER_BIT cycles.
// - Back-to-back period: frame length + 1 cycle, because the accept happens in the IDLE cycle.
// - tdata/tvalid are ignored while tready=0. The upstream source holds tvalid and tdata stable until the handshake.
// - tvalid dropping before acceptance is legal; nothing is sent.
// - Reset mid-frame: txd=1 on the next edge and the frame is truncated. The latched byte is discarded and not resent.
// - If tvalid=1 in the first IDLE cycle after reset, the byte is accepted in that cycle.
// CONFIGURATION
// - UART_TX_PARITY_EN defined:
//   - A PARITY state is inserted after DATA, for one bit time.
//   - txd = XOR of the DATA_WIDTH payload bits (even parity).
//   - Frame = (3+DATA_WIDTH)*CLKS_PER_BIT.
// - UART_TX_PARITY_EN undefined:
//   - No PARITY state and no parity logic.
//   - Frame = (2+DATA_WIDTH)*CLKS_PER_BIT (8N1).
// TESTING
// - Default parameters except CLKS_PER_BIT=4.
// - Scenario 1: send 0xA5 -> txd, sampled each 4 cycles from the start edge, = 0,1,0,1,0,0,1,0,1,1.
//   - txd falls 1 cycle after the handshake; busy is high for 40 cycles; tready returns 1 at cycle 41.
// - Scenario 2: 0x00 then 0xFF, tvalid held high -> second start edge exactly 41 cycles after the first.
//   - Data bits are all 0, then all 1.
// - Scenario 3: tvalid=1 with 0x3C while busy -> no second acceptance until IDLE.
//   - 0x3C is sent once; no corruption of the frame in flight.
// - Scenario 4: assert rst for 1 cycle during data bit 3 of 0x55 -> txd=1 on the next edge, tready=0 during rst.
//   - tready=1 the cycle after.
//   - Then sending 0x81 yields a clean frame 0,1,0,0,0,0,0,0,1,1.
// - Scenario 5 (UART_TX_PARITY_EN): send 0x07 -> parity bit 1; send 0x03 -> parity bit 0.
//   - Frame is 44 cycles; stop bit follows parity.
// - Checker: a bit-level model samples mid-bit and compares every frame against the accepted byte queue.

Source files
------------

// File: rtl/uart_tx_out_if.sv
// rtl/uart_tx_out_if.sv - byte stream handshake into the UART transmitter
//
// Carries the payload word and its valid/ready handshake.
//   s_axis_tdata   DATA_WIDTH  word to send (source -> transmitter)
//   s_axis_tvalid  1           tdata valid  (source -> transmitter)
//   s_axis_tready  1           transmitter can accept a word (transmitter -> source)
// Modports: master = the byte source, slave = the transmitter.
interface uart_tx_out_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;

    modport master (
        output s_axis_tdata,
        output s_axis_tvalid,
        input  s_axis_tready
    );

    modport slave (
        input  s_axis_tdata,
        input  s_axis_tvalid,
        output s_axis_tready
    );
endinterface

// File: rtl/uart_tx_out.sv
// rtl/uart_tx_out.sv - UART transmitter, start/data[/parity]/stop framing, LSB first
//
// Serialises words taken from a valid/ready stream. One start bit (0), DATA_WIDTH
// payload bits LSB first, an optional even-parity bit, one stop bit (1). Every bit
// lasts CLKS_PER_BIT clocks. All outputs come straight from flops so txd can drive
// the pad buffer with no logic in between.
//
// Ports:
//   clk     in   system clock
//   rst     in   synchronous reset, active-high
//   s_axis  slave modport of uart_tx_out_if (tdata/tvalid in, tready out)
//   txd     out  serial line, idles high, registered
//   busy    out  high while a frame is on the line, registered
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between
// the last data bit and the stop bit.
module uart_tx_out #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic         clk,
    input  logic         rst,
    uart_tx_out_if.slave s_axis,
    output logic         txd,
    output logic         busy
);

    localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("uart_tx_out: CLKS_PER_BIT must be at least 2");
        end
        if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
            $error("uart_tx_out: DATA_WIDTH must be in 5..9");
        end
    endgenerate

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;
`endif

    state_t                state_q, state_d;
    logic [PW-1:0]         pre_cnt_q, pre_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  txd_q, txd_d;
    logic                  tready_q, tready_d;
    logic                  busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    logic bit_done;
    logic accept;

    // Last clock of the current bit time.
    assign bit_done = (pre_cnt_q == PRE_LAST);
    // Handshake uses the registered tready, so tdata/tvalid are ignored while busy.
    assign accept   = tready_q && s_axis.s_axis_tvalid;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pre_cnt_q <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            txd_q     <= 1'b1;
            tready_q  <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            txd_q     <= txd_d;
            tready_q  <= tready_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        // Prescaler idles at 0 and reloads at every bit boundary.
        if (state_q != S_IDLE) begin
            pre_cnt_d = bit_done ? '0 : pre_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_START;
                    shreg_d   = s_axis.s_axis_tdata;
                    bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^s_axis.s_axis_tdata;
`endif
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: decoded from the next state so the flops present the
    // new line level in the same cycle the state register moves.
    always_comb begin
        txd_d    = 1'b1;
        tready_d = 1'b0;
        busy_d   = 1'b1;
        case (state_d)
            S_IDLE: begin
                tready_d = 1'b1;
                busy_d   = 1'b0;
            end
            S_START: begin
                txd_d = 1'b0;
            end
            S_DATA: begin
                txd_d = shreg_d[0];
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                txd_d = parity_d;
            end
`endif
            S_STOP: begin
                txd_d = 1'b1;
            end
            default: begin
                txd_d = 1'b1;
            end
        endcase
    end

    assign txd                  = txd_q;
    assign busy                 = busy_q;
    assign s_axis.s_axis_tready = tready_q;

endmodule

// File: tb/tb_uart_tx_out.sv
// tb/tb_uart_tx_out.sv - self-checking bench for uart_tx_out
`timescale 1ns/1ps
module tb_uart_tx_out;
    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = DW + 3;
`else
    localparam int NBITS = DW + 2;
`endif
    localparam int FRAME = NBITS * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic txd;
    logic busy;

    uart_tx_out_if #(.DATA_WIDTH(DW)) axis ();

    uart_tx_out #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .s_axis(axis.slave),
        .txd   (txd),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: line waveform as a function of the accept time.
    int            cyc      = 0;
    bit            m_valid  = 0;
    bit            m_active = 0;
    bit            m_rdy    = 0;
    int            m_acc    = 0;
    int            last_acc = -1;
    int            n_acc    = 0;
    bit            m_bits [NBITS];
    logic [DW-1:0] acc_q [$];
    bit            dec_abort = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            if (m_active) begin
                dec_abort = 1;
                // Drop the truncated byte unless the decoder already consumed it.
                if ((cyc - 1 - m_acc) < (NBITS - 1) * CPB + CPB / 2 && acc_q.size() > 0)
                    void'(acc_q.pop_back());
            end
            m_active = 0;
            m_rdy    = 0;
            m_valid  = 1;
        end else if (m_active) begin
            if (cyc - m_acc == FRAME) begin
                m_active = 0;
                m_rdy    = 1;
            end
        end else if (m_rdy && axis.s_axis_tvalid === 1'b1) begin
            m_active = 1;
            m_rdy    = 0;
            m_acc    = cyc;
            last_acc = cyc;
            n_acc++;
            m_bits[0] = 1'b0;
            for (int i = 0; i < DW; i++) m_bits[1 + i] = axis.s_axis_tdata[i];
`ifdef UART_TX_PARITY_EN
            m_bits[DW + 1] = ^axis.s_axis_tdata;
`endif
            m_bits[NBITS - 1] = 1'b1;
            acc_q.push_back(axis.s_axis_tdata);
        end else begin
            m_rdy = 1;
        end
    end

    // Per-cycle compare plus a mid-bit sampling receiver.
    logic            exp_txd;
    bit              prev_txd  = 1;
    bit              dec_busy  = 0;
    int              dec_cnt   = 0;
    int              n_frames  = 0;
    logic [0:NBITS-1] dec_bits;
    logic [DW-1:0]   dec_data;
    logic [DW-1:0]   dec_exp;

    always @(negedge clk) begin
        if (m_valid) begin
            exp_txd = m_active ? m_bits[(cyc - m_acc) / CPB] : 1'b1;
            chk("cyc_txd", 32'(txd), 32'(exp_txd));
            chk("cyc_busy", 32'(busy), 32'(m_active));
            chk("cyc_tready", 32'(axis.s_axis_tready), 32'(m_active ? 1'b0 : m_rdy));

            if (dec_abort) begin
                dec_busy  = 0;
                dec_abort = 0;
            end else if (!dec_busy) begin
                if (prev_txd && txd === 1'b0) begin
                    dec_busy = 1;
                    dec_cnt  = 0;
                end
            end else begin
                dec_cnt++;
            end
            if (dec_busy && (dec_cnt % CPB) == CPB / 2) begin
                dec_bits[dec_cnt / CPB] = txd;
                if (dec_cnt / CPB == NBITS - 1) begin
                    for (int i = 0; i < DW; i++) dec_data[i] = dec_bits[1 + i];
                    dec_exp = (acc_q.size() > 0) ? acc_q.pop_front() : 'x;
                    chk("rx_start", 32'(dec_bits[0]), 32'(1'b0));
                    chk("rx_data", 32'(dec_data), 32'(dec_exp));
`ifdef UART_TX_PARITY_EN
                    chk("rx_parity", 32'(dec_bits[DW + 1]), 32'(^dec_exp));
`endif
                    chk("rx_stop", 32'(dec_bits[NBITS - 1]), 32'(1'b1));
                    n_frames++;
                    dec_busy = 0;
                end
            end
            prev_txd = (txd === 1'b1);
        end
    end

    // Present a word and return once it has been accepted (at the o=0 negedge).
    task automatic send(input logic [DW-1:0] b, output int acc_at);
        int n = 0;
        axis.s_axis_tdata  = b;
        axis.s_axis_tvalid = 1'b1;
        while (axis.s_axis_tready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("handshake_timeout", 32'(n < 200), 32'd1);
        @(negedge clk);
        acc_at = last_acc;
    endtask

    // Starting at the o=0 negedge: collect mid-bit samples and busy length.
    task automatic run_frame(input string tag, input logic [0:NBITS-1] exp_seq);
        logic [0:NBITS-1] got;
        int nb = 0;
        got = '0;
        chk({tag, "_start_edge"}, 32'(txd), 32'd0);
        for (int o = 0; o <= FRAME; o++) begin
            if (o > 0) @(negedge clk);
            if (busy === 1'b1) nb++;
            if ((o % CPB) == CPB / 2 && o / CPB < NBITS) got[o / CPB] = txd;
        end
        chk({tag, "_bits"}, 32'(got), 32'(exp_seq));
        chk({tag, "_busy_len"}, 32'(nb), 32'(FRAME));
        chk({tag, "_tready_back"}, 32'(axis.s_axis_tready), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy !== 1'b0 || axis.s_axis_tready !== 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(n < 200), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int a1, a2, acc_before;

    initial begin
        axis.s_axis_tdata  = '0;
        axis.s_axis_tvalid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_txd", 32'(txd), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_tready", 32'(axis.s_axis_tready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_tready", 32'(axis.s_axis_tready), 32'd1);

        // Scenario 1: 0xA5
        chk("s1_idle_txd", 32'(txd), 32'd1);
        send(8'hA5, a1);
        axis.s_axis_tvalid = 1'b0;
`ifdef UART_TX_PARITY_EN
        run_frame("s1", 11'b01010010101);
`else
        run_frame("s1", 10'b0101001011);
`endif
        repeat (3) @(negedge clk);

        // Scenario 2: 0x00 then 0xFF with tvalid held
        send(8'h00, a1);
        axis.s_axis_tdata = 8'hFF;
        send(8'hFF, a2);
        axis.s_axis_tvalid = 1'b0;
        chk("s2_period", 32'(a2 - a1), 32'(FRAME + 1));
`ifdef UART_TX_PARITY_EN
        run_frame("s2", 11'b01111111101);
`else
        run_frame("s2", 10'b0111111111);
`endif
        repeat (2) @(negedge clk);

        // Scenario 3: 0x3C offered throughout the 0x96 frame
        acc_before = n_acc;
        send(8'h96, a1);
        axis.s_axis_tdata = 8'h3C;
        repeat (10) @(negedge clk);
        chk("s3_no_early_accept", 32'(n_acc - acc_before), 32'd1);
        send(8'h3C, a2);
        axis.s_axis_tvalid = 1'b0;
        chk("s3_accept_at_idle", 32'(a2 - a1), 32'(FRAME + 1));
        chk("s3_accept_count", 32'(n_acc - acc_before), 32'd2);
        wait_idle();
        repeat (2) @(negedge clk);

        // Scenario 4: reset during data bit 3 of 0x55
        send(8'h55, a1);
        axis.s_axis_tvalid = 1'b0;
        repeat (4 * (1 + 3) + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("s4_rst_txd", 32'(txd), 32'd1);
        chk("s4_rst_tready", 32'(axis.s_axis_tready), 32'd0);
        chk("s4_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("s4_tready_after", 32'(axis.s_axis_tready), 32'd1);
        send(8'h81, a1);
        axis.s_axis_tvalid = 1'b0;
`ifdef UART_TX_PARITY_EN
        run_frame("s4", 11'b01000000101);
`else
        run_frame("s4", 10'b0100000011);
`endif

`ifdef UART_TX_PARITY_EN
        // Scenario 5: parity bit values
        send(8'h07, a1);
        axis.s_axis_tvalid = 1'b0;
        run_frame("s5a", 11'b01110000011);
        send(8'h03, a1);
        axis.s_axis_tvalid = 1'b0;
        run_frame("s5b", 11'b01100000001);
`endif

        repeat (10) @(negedge clk);
        chk("queue_drained", 32'(acc_q.size()), 32'd0);
`ifdef UART_TX_PARITY_EN
        chk("total_accepts", 32'(n_acc), 32'd9);
        chk("total_frames", 32'(n_frames), 32'd8);
`else
        chk("total_accepts", 32'(n_acc), 32'd7);
        chk("total_frames", 32'(n_frames), 32'd6);
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
